memory_access: RTL

Memory access (ma) stage of the riscv-small pipeline. It sits between the execution stage and write back (wb). It takes the registered ALU result, store data, control and load funct3 produced by execution, and runs a req/ack transaction on the data memory port. It aligns and extends load data, builds the store byte lanes, stalls the pipeline while memory is slow, and registers the result for wb.

---
 rtl/riscv_definitions.sv | 16 +
 rtl/load_store_align.sv | 38 +++
 rtl/memory_access.sv | 113 +++++++++++
 3 files changed

// File: rtl/riscv_definitions.sv
// riscv_definitions: shared types for the riscv-small pipeline stages.
package riscv_definitions;
    typedef logic [4:0] regAddr_t;
    typedef logic [3:0] byteEnable_t;
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3ITypeLOAD_e;
    localparam funct3ITypeLOAD_e SB = LB;
    localparam funct3ITypeLOAD_e SH = LH;
    localparam funct3ITypeLOAD_e SW = LW;
    typedef enum logic {IDLE, WAIT} maState_e;
endpackage

// File: rtl/load_store_align.sv
// load_store_align: store byte-lane/enable generation and load extraction/extension.
// MISALIGN_TRAP_EN flags misaligned accesses; otherwise low address bits are masked.
module load_store_align
    import riscv_definitions::*;
(
    input  funct3ITypeLOAD_e funct3,
    input  logic [1:0]       a,
    input  logic [31:0]      rs2,
    input  logic             ld,
    output byteEnable_t      be,
    output logic [31:0]      wdata,
    output logic [1:0]       off,
    output logic             misaligned,
    input  funct3ITypeLOAD_e ld_funct3,
    input  logic [1:0]       ld_off,
    input  logic [31:0]      rdata,
    output logic [31:0]      ld_data
);
    logic half, word;
    logic [31:0] sh;
    always_comb begin
        half = funct3[1:0] == 2'b01;
        word = funct3[1:0] == 2'b10;
`ifdef MISALIGN_TRAP_EN
        misaligned = (half & a[0]) | (word & |a);
`else
        misaligned = 1'b0;
`endif
        off = word ? 2'b00 : half ? {a[1], 1'b0} : a;
        be = ld ? 4'b1111 : half ? 4'b0011 << {a[1], 1'b0} : word ? 4'b1111 : 4'b0001 << a;
        wdata = half ? {2{rs2[15:0]}} : word ? rs2 : {4{rs2[7:0]}};
        sh = rdata >> {ld_off, 3'b000};
        ld_data = ld_funct3 == LB  ? {{24{sh[7]}}, sh[7:0]} :
                  ld_funct3 == LH  ? {{16{sh[15]}}, sh[15:0]} :
                  ld_funct3 == LBU ? {24'h0, sh[7:0]} :
                  ld_funct3 == LHU ? {16'h0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: MA stage running the req/ack data-memory transaction and registering the wb result.
// Build option MISALIGN_TRAP_EN turns misaligned accesses into a bus error instead of masking them.
module memory_access
    import riscv_definitions::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [31:0]      alu_ma,
    input  logic [31:0]      rs2_ma,
    input  logic             rd0_wr_en_ma,
    input  logic             data_rd_en_ma,
    input  logic             data_wr_en_ma,
    input  funct3ITypeLOAD_e funct3_ma,
    input  regAddr_t         rd0_addr_ma,
    output logic             data_req,
    output logic             data_we,
    output logic [31:0]      data_addr,
    output byteEnable_t      data_be,
    output logic [31:0]      data_wdata,
    input  logic             data_ack,
    input  logic [31:0]      data_rdata,
    output logic             stall_ma,
    output logic [31:0]      rd0_data_wb,
    output regAddr_t         rd0_addr_wb,
    output logic             rd0_wr_en_wb,
    output logic             bus_err_wb
);
    maState_e state;
    logic [7:0] cnt;
    logic [29:0] lat_addr;
    logic lat_we, lat_rd_wr_en;
    byteEnable_t lat_be, be;
    logic [31:0] lat_wdata, wdata, ld_data;
    funct3ITypeLOAD_e lat_funct3;
    logic [1:0] lat_off, off;
    regAddr_t lat_rd_addr;
    logic access, we, trap, waiting, misaligned;

    load_store_align u_align (
        .funct3(funct3_ma), .a(alu_ma[1:0]), .rs2(rs2_ma), .ld(~we),
        .be(be), .wdata(wdata), .off(off), .misaligned(misaligned),
        .ld_funct3(waiting ? lat_funct3 : funct3_ma), .ld_off(waiting ? lat_off : off),
        .rdata(data_rdata), .ld_data(ld_data)
    );

    // In WAIT the bus is driven purely from the latches so it stays stable until ack
    always_comb begin
        access = data_rd_en_ma | data_wr_en_ma;
        we = data_wr_en_ma & ~data_rd_en_ma;
        trap = access & misaligned;
        waiting = state == WAIT;
        data_req = ~rst & (waiting | (access & clk_en & ~trap));
        data_we = data_req & (waiting ? lat_we : we);
        data_addr = data_req ? {waiting ? lat_addr : alu_ma[31:2], 2'b00} : 32'h0;
        data_be = data_req ? (waiting ? lat_be : be) : 4'h0;
        data_wdata = data_req ? (waiting ? lat_wdata : wdata) : 32'h0;
        stall_ma = ~rst & ~data_ack & (waiting ? cnt < 8'(WAIT_MAX) : access & ~trap);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            lat_addr <= '0;
            lat_we <= 1'b0;
            lat_be <= '0;
            lat_wdata <= '0;
            lat_funct3 <= LB;
            lat_off <= '0;
            lat_rd_addr <= '0;
            lat_rd_wr_en <= 1'b0;
            rd0_data_wb <= '0;
            rd0_addr_wb <= '0;
            rd0_wr_en_wb <= 1'b0;
            bus_err_wb <= 1'b0;
        end else if (clk_en) begin
            rd0_wr_en_wb <= 1'b0;
            bus_err_wb <= 1'b0;
            if (waiting) begin
                cnt <= cnt + 8'd1;
                if (data_ack) begin
                    state <= IDLE;
                    rd0_data_wb <= lat_we ? alu_ma : ld_data;
                    rd0_addr_wb <= lat_rd_addr;
                    rd0_wr_en_wb <= lat_rd_wr_en & ~lat_we;
                end else if (cnt == 8'(WAIT_MAX)) begin
                    state <= IDLE;
                    bus_err_wb <= 1'b1;
                end
            end else if (trap) begin
                bus_err_wb <= 1'b1;
            end else if (access & ~data_ack) begin
                state <= WAIT;
                cnt <= '0;
                lat_addr <= alu_ma[31:2];
                lat_we <= we;
                lat_be <= be;
                lat_wdata <= wdata;
                lat_funct3 <= funct3_ma;
                lat_off <= off;
                lat_rd_addr <= rd0_addr_ma;
                lat_rd_wr_en <= rd0_wr_en_ma;
            end else begin
                rd0_data_wb <= access & ~we ? ld_data : alu_ma;
                rd0_addr_wb <= rd0_addr_ma;
                rd0_wr_en_wb <= rd0_wr_en_ma & ~(access & we);
            end
        end
    end
endmodule
